// File: rtl/mux_oht_pkg.sv
// Shared definitions for the pipelined one-hot mux tree.
//   tree_levels : number of SPLIT-way levels needed to reduce WIDTH entries,
//                 or -1 when WIDTH is not an exact power of SPLIT (or SPLIT<2)
//   popcount    : number of set bits in a register-placement mask (= latency)
//   hs_t        : handshake/status bundle {vld, hit}
package mux_oht_pkg;

    typedef struct packed {
        logic vld;
        logic hit;
    } hs_t;

    function automatic int tree_levels(input int unsigned width, input int unsigned split);
        int unsigned acc;
        int          lv;
        acc = 1;
        lv  = 0;
        if (split < 2 || width < 2) begin
            return -1;
        end
        while (acc < width) begin
            acc = acc * split;
            lv  = lv + 1;
        end
        return (acc == width) ? lv : -1;
    endfunction

    function automatic int unsigned popcount(input logic [31:0] mask, input int unsigned nbits);
        int unsigned cnt;
        cnt = 0;
        for (int unsigned i = 0; i < nbits && i < 32; i++) begin
            cnt = cnt + 32'(mask[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/mux_oht_base.sv
// Combinational one-hot (AND-OR) mux node.
//   oht            : select vector, one bit per entry (multi-hot ORs entries)
//   ary            : packed array of WIDTH data entries
//   dat            : OR of all entries whose select bit is set; 0 when none
// IMPLEMENTATION 0 is a per-entry AND-OR; any other value builds the same
// function as a per-bit column reduction.
module mux_oht_base #(
    parameter int unsigned WIDTH          = 2,
    parameter type         DAT_T          = logic [7:0],
    parameter int unsigned IMPLEMENTATION = 0
) (
    input  logic [WIDTH-1:0] oht,
    input  DAT_T [WIDTH-1:0] ary,
    output DAT_T             dat
);

    localparam int unsigned DW = $bits(DAT_T);

    logic [WIDTH-1:0][DW-1:0] ary_v;
    logic [DW-1:0]            acc;

    assign ary_v = ary;
    assign dat   = DAT_T'(acc);

    if (IMPLEMENTATION == 0) begin : g_andor
        always_comb begin
            acc = '0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                acc = acc | (ary_v[i] & {DW{oht[i]}});
            end
        end
    end else begin : g_column
        for (genvar b = 0; b < DW; b++) begin : g_bit
            logic [WIDTH-1:0] col;
            for (genvar i = 0; i < WIDTH; i++) begin : g_ent
                assign col[i] = ary_v[i][b];
            end
            assign acc[b] = |(col & oht);
        end
    end

endmodule

// File: rtl/mux_oht_pipe_reg.sv
// Generic valid/ready pipeline register carrying LANES hit bits and data words.
//   clk, rst_n     : clock, asynchronous active-low reset
//   vld_up/rdy_up  : upstream handshake (rdy_up = stage empty or draining)
//   hit_up/dat_up  : upstream payload
//   vld_dn/rdy_dn  : downstream handshake
//   hit_dn/dat_dn  : registered payload
// Full throughput without a skid buffer: ready passes backward combinationally.
module mux_oht_pipe_reg #(
    parameter type         DAT_T = logic [7:0],
    parameter int unsigned LANES = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   vld_up,
    output logic                   rdy_up,
    input  logic [LANES-1:0]       hit_up,
    input  DAT_T [LANES-1:0]       dat_up,
    output logic                   vld_dn,
    input  logic                   rdy_dn,
    output logic [LANES-1:0]       hit_dn,
    output DAT_T [LANES-1:0]       dat_dn
);

    logic                 vld_q;
    logic [LANES-1:0]     hit_q;
    DAT_T [LANES-1:0]     dat_q;

    assign rdy_up = !vld_q || rdy_dn;
    assign vld_dn = vld_q;
    assign hit_dn = hit_q;
    assign dat_dn = dat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            hit_q <= '0;
            dat_q <= '0;
        end else if (rdy_up) begin
            vld_q <= vld_up;
            // Payload only moves with a real item so idle cycles do not toggle it.
            if (vld_up) begin
                hit_q <= hit_up;
                dat_q <= dat_up;
            end
        end
    end

endmodule

// File: rtl/mux_oht_tree_pipe.sv
// Pipelined one-hot select multiplexer tree.
//   clk, rst_n      : clock, asynchronous active-low reset
//   in_vld/in_rdy   : input handshake
//   oht             : WIDTH-bit one-hot (or zero / multi-hot) select
//   ary             : WIDTH data entries
//   out_vld/out_rdy : output handshake
//   out_hit         : OR-reduction of the transferred oht
//   out_dat         : selected data (OR of selected entries, 0 if none)
// Level l reduces WIDTH/SPLIT**l entries by SPLIT; REG_MASK[l] places a
// pipeline register after level l, otherwise the level is a pass-through.
module mux_oht_tree_pipe
    import mux_oht_pkg::*;
#(
    parameter type         DAT_T          = logic [8-1:0],
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned SPLIT          = 2,
    parameter logic [31:0] REG_MASK       = '1,
    parameter int unsigned IMPLEMENTATION = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] oht,
    input  DAT_T             ary [WIDTH],
    output logic             out_vld,
    input  logic             out_rdy,
    output logic             out_hit,
    output DAT_T             out_dat
);

    localparam int LEVELS_RAW = tree_levels(WIDTH, SPLIT);
    // Clamp keeps the generate loops well-formed while the fatal below reports.
    localparam int LEVELS     = (LEVELS_RAW < 1) ? 1 : LEVELS_RAW;
    localparam int DW         = $bits(DAT_T);

    typedef logic [DW-1:0] dat_t;

    if (LEVELS_RAW < 1) begin : g_bad_cfg
        $fatal(1, "mux_oht_tree_pipe: WIDTH=%0d is not a power of SPLIT=%0d (SPLIT must be >= 2)",
               WIDTH, SPLIT);
    end

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int unsigned N_IN  = WIDTH / (SPLIT ** l);
        localparam int unsigned N_OUT = N_IN / SPLIT;

        logic              vld_i;
        logic              rdy_o;
        logic              rdy_i;
        logic              vld_o;
        logic [N_IN-1:0]   hit_i;
        dat_t [N_IN-1:0]   dat_i;
        logic [N_OUT-1:0]  hit_c;
        dat_t [N_OUT-1:0]  dat_c;
        logic [N_OUT-1:0]  hit_o;
        dat_t [N_OUT-1:0]  dat_o;

        if (l == 0) begin : g_src
            assign vld_i = in_vld;
            assign hit_i = oht;
            for (genvar j = 0; j < N_IN; j++) begin : g_leaf
                assign dat_i[j] = ary[j];
            end
        end else begin : g_src
            assign vld_i = g_lvl[l-1].vld_o;
            assign hit_i = g_lvl[l-1].hit_o;
            assign dat_i = g_lvl[l-1].dat_o;
        end

        if (l == LEVELS - 1) begin : g_sink
            assign rdy_i = out_rdy;
        end else begin : g_sink
            assign rdy_i = g_lvl[l+1].rdy_o;
        end

        for (genvar n = 0; n < N_OUT; n++) begin : g_node
            assign hit_c[n] = |hit_i[n*SPLIT +: SPLIT];
            mux_oht_base #(
                .WIDTH          (SPLIT),
                .DAT_T          (dat_t),
                .IMPLEMENTATION (IMPLEMENTATION)
            ) u_mux (
                .oht (hit_i[n*SPLIT +: SPLIT]),
                .ary (dat_i[n*SPLIT +: SPLIT]),
                .dat (dat_c[n])
            );
        end

        if (REG_MASK[l]) begin : g_reg
            mux_oht_pipe_reg #(
                .DAT_T (dat_t),
                .LANES (N_OUT)
            ) u_reg (
                .clk    (clk),
                .rst_n  (rst_n),
                .vld_up (vld_i),
                .rdy_up (rdy_o),
                .hit_up (hit_c),
                .dat_up (dat_c),
                .vld_dn (vld_o),
                .rdy_dn (rdy_i),
                .hit_dn (hit_o),
                .dat_dn (dat_o)
            );
        end else begin : g_thru
            assign vld_o = vld_i;
            assign rdy_o = rdy_i;
            assign hit_o = hit_c;
            assign dat_o = dat_c;
        end
    end

    hs_t out_hs;

    assign out_hs  = '{vld: g_lvl[LEVELS-1].vld_o, hit: g_lvl[LEVELS-1].hit_o[0]};
    assign in_rdy  = g_lvl[0].rdy_o;
    assign out_vld = out_hs.vld;
    assign out_hit = out_hs.hit;
    assign out_dat = DAT_T'(g_lvl[LEVELS-1].dat_o[0]);

endmodule

// File: doc/mux_oht_tree_pipe.md
Name: mux_oht_tree_pipe

Overview:
Pipelined one-hot select multiplexer tree that generalises the combinational one-hot mux tree.
- Reduces WIDTH data entries by SPLIT-way one-hot muxing per tree level.
- Inserts an optional register stage after any level, with a valid/ready handshake and full backpressure.
- Used where wide one-hot selects, e.g. arbiter grants or CAM hit vectors, do not close timing in one cycle.

Parameters:
- DAT_T, logic [8-1:0]: data element type.
- WIDTH, 32: number of data entries. Must equal SPLIT**LEVELS; checked at elaboration, fatal otherwise.
- SPLIT, 2: fan-in per tree node. Must be ≥2.
- LEVELS (localparam), log_SPLIT(WIDTH): number of tree levels. Level 0 is at the leaves.
- REG_MASK, {LEVELS{1'b1}}: bit l=1 places a pipeline register after level l.
- IMPLEMENTATION, 0: node mux implementation, passed through to mux_oht_base.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- in_vld  input  1  input transfer valid
- in_rdy  output  1  input transfer ready
- oht  input  WIDTH  one-hot select
- ary  input  DAT_T[WIDTH]  data array
- out_vld  output  1  output valid
- out_rdy  input  1  output ready
- out_hit  output  1  OR-reduction of oht
- out_dat  output  DAT_T  selected data

Behaviour:
- One clock, clk. rst_n is asynchronous active-low, asserted asynchronously and released synchronously to clk.
- Reset: every stage valid flag, hit register and data register clears to 0. Therefore out_vld=0, out_hit=0, out_dat=0 while in reset.
- Latency: L = popcount(REG_MASK) cycles from input transfer to out_vld, with no stall.
  - With REG_MASK=0 the block is purely combinational: out_vld=in_vld, in_rdy=out_rdy, out_hit/out_dat follow in the same cycle.
- Transfer rule: a transfer occurs on a rising clk edge when vld && rdy.
  - Once vld is raised, the producer holds vld and the payload stable until rdy.
  - Valid never depends combinationally on rdy.
- Per-level node logic:
  - Node hit = OR of its SPLIT child hits. Leaf hit = oht bit.
  - Node data = AND-OR of child data gated by child hit.
- Register stage s, fed by the previous stage's vld/hit/dat and the next stage's rdy:
  - rdy_up = !vld_q || rdy_dn.
  - On rdy_up, load vld_q<=vld_up and load hit_q/dat_q. Load the payload only when vld_up, to reduce toggling.
  - Otherwise hold all state.
- Throughput is one transfer per cycle with out_rdy held high. A bubble-free stall propagates ready backward combinationally through all stages. No skid buffers.
- Boundary conditions:
  - oht all-zero: out_hit=0, out_dat=0. The transfer still completes with out_vld=1.
  - oht multi-hot: out_hit=1, out_dat = bitwise OR of all selected entries. Defined behaviour, not an error.
  - out_rdy=0 with the pipe full: in_rdy=0 within the same cycle. No data is lost or duplicated.
  - Load and unload in the same cycle at a full stage: both occur; the stage stays full.
  - Reset asserted mid-stream: all in-flight items are discarded. After release the pipe is empty and in_rdy=1.
- Ordering: strict FIFO order. No reordering or merging.

Decomposition:
- Package mux_oht_pkg:
  - function tree_levels(width, split): returns LEVELS and flags a non-power width.
  - function popcount for REG_MASK, used to compute latency.
  - typedef of the handshake struct {vld, hit}.
- Sub-modules:
  - mux_oht_base: node muxing, reused unchanged.
  - mux_oht_pipe_reg: one generic valid/ready pipeline register, parametrised by DAT_T and carrying hit+dat. Instantiated per level where REG_MASK[l]=1; a pass-through is generated otherwise.
- Tree built with generate loops over levels and nodes.

Test Plan:
- Defaults (WIDTH=32, SPLIT=2, REG_MASK=5'b11111), out_rdy=1:
  - stream oht=1<<i, ary[j]=j+8'h40 for i=0..31 → out_dat=8'h40+i, out_hit=1, 5 cycles after each input transfer, one per cycle.
- oht=0 with ary all 8'hFF → out_vld=1, out_hit=0, out_dat=8'h00.
- Multi-hot oht=32'h0000_0011, ary[0]=8'h0F, ary[4]=8'hF0 → out_dat=8'hFF, out_hit=1.
- Backpressure:
  - Hold out_rdy=0 while streaming 10 items → in_rdy falls after exactly 5 accepted.
  - Release out_rdy → all 10 items emerge in order without gaps or duplicates.
  - Also run with out_rdy toggling randomly 50%, checked against a scoreboard.
- Reset mid-stream: rst_n low for 1 cycle with 3 items in flight → out_vld=0, out_dat=0 immediately (asynchronous). After release in_rdy=1 and no stale item appears.
- Configurations WIDTH=64/SPLIT=4 with REG_MASK=3'b010 (latency 1) and REG_MASK=0:
  - the REG_MASK=0 case is combinational, with a same-cycle out_vld→in_rdy path equal to out_rdy.
  - Output matches the golden model. Elaboration with WIDTH=24, SPLIT=2 is fatal.
